// File: rtl/tl_ul_arb2_if.sv
// TileLink-UL/UH link bundle (A and D channels) for one point-to-point hop.
// The master modport is the side that issues A requests and accepts D responses.
interface tl_ul_arb2_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 2
);
  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            a_opcode;
  logic [2:0]            a_param;
  logic [2:0]            a_size;
  logic [SRC_W-1:0]      a_source;
  logic [ADDR_W-1:0]     a_address;
  logic [DATA_W/8-1:0]   a_mask;
  logic [DATA_W-1:0]     a_data;
  logic                  a_corrupt;

  logic                  d_valid;
  logic                  d_ready;
  logic [2:0]            d_opcode;
  logic [1:0]            d_param;
  logic [2:0]            d_size;
  logic [SRC_W-1:0]      d_source;
  logic                  d_sink;
  logic                  d_denied;
  logic                  d_corrupt;
  logic [DATA_W-1:0]     d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_arb2.sv
// Two-master TileLink-UL/UH arbiter onto one slave port.
// A channel: round-robin between masters, grant held across a stalled beat and
// locked for the remaining beats of a multi-beat Put. The slave source gets the
// owner index prepended; D responses are steered back by that bit.
//
// state    | meaning
// ST_IDLE  | free arbitration (round-robin on contention)
// ST_HOLD  | a beat from owner_q is presented but not yet accepted
// ST_BURST | owner_q is mid Put burst, beats_left_q beats still to come
module tl_ul_arb2 #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  tl_ul_arb2_if.slave  m0_if,
  tl_ul_arb2_if.slave  m1_if,
  tl_ul_arb2_if.master s_if
);

  localparam logic [2:0] LGB            = 3'd2;
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [7:0] beats_left_q, beats_left_d;
  logic       rr_last_q, rr_last_d;

  logic       grant;
  logic       a_valid;
  logic       a_fire;
  logic [2:0] a_opcode;
  logic [2:0] a_size;
  logic       is_burst;
  logic [8:0] burst_span;

  // Grant: sticky owner while held or locked, else lone requester, else round-robin.
  always_comb begin
    grant = ~rr_last_q;
    case (state_q)
      ST_HOLD, ST_BURST: grant = owner_q;
      default: begin
        if (m0_if.a_valid != m1_if.a_valid) grant = m1_if.a_valid;
      end
    endcase
  end

  assign a_valid  = grant ? m1_if.a_valid  : m0_if.a_valid;
  assign a_opcode = grant ? m1_if.a_opcode : m0_if.a_opcode;
  assign a_size   = grant ? m1_if.a_size   : m0_if.a_size;
  assign a_fire   = a_valid & s_if.a_ready;

  assign s_if.a_valid   = a_valid;
  assign s_if.a_opcode  = a_opcode;
  assign s_if.a_param   = grant ? m1_if.a_param   : m0_if.a_param;
  assign s_if.a_size    = a_size;
  assign s_if.a_source  = {grant, (grant ? m1_if.a_source : m0_if.a_source)};
  assign s_if.a_address = grant ? m1_if.a_address : m0_if.a_address;
  assign s_if.a_mask    = grant ? m1_if.a_mask    : m0_if.a_mask;
  assign s_if.a_data    = grant ? m1_if.a_data    : m0_if.a_data;
  assign s_if.a_corrupt = grant ? m1_if.a_corrupt : m0_if.a_corrupt;

  assign m0_if.a_ready = s_if.a_ready & ~grant;
  assign m1_if.a_ready = s_if.a_ready &  grant;

  // Beats in a burst = 2^(size-LGB); only meaningful when size > LGB.
  assign is_burst   = ((a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL)) && (a_size > LGB);
  assign burst_span = 9'd1 << (a_size - LGB);

  // Next-state: burst countdown, first-beat lock/round-robin update, stall hold.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    rr_last_d    = rr_last_q;
    case (state_q)
      ST_BURST: begin
        if (a_fire) begin
          beats_left_d = beats_left_q - 8'd1;
          if (beats_left_q == 8'd1) state_d = ST_IDLE;
        end
      end
      default: begin
        if (a_fire) begin
          rr_last_d = grant;
          state_d   = ST_IDLE;
          if (is_burst) begin
            state_d      = ST_BURST;
            owner_d      = grant;
            beats_left_d = 8'(burst_span - 9'd1);
          end
        end else if (a_valid) begin
          state_d = ST_HOLD;
          owner_d = grant;
        end
      end
    endcase
  end

  // State register; reset drops any lock/hold and favours m0 on first contention.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      beats_left_q <= 8'd0;
      rr_last_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      rr_last_q    <= rr_last_d;
    end
  end

  // D channel is stateless: the top source bit names the master that asked.
  logic d_tag;
  assign d_tag = s_if.d_source[SRC_W];

  assign m0_if.d_valid = s_if.d_valid & ~d_tag;
  assign m1_if.d_valid = s_if.d_valid &  d_tag;
  assign s_if.d_ready  = d_tag ? m1_if.d_ready : m0_if.d_ready;

  assign m0_if.d_opcode  = s_if.d_opcode;
  assign m0_if.d_param   = s_if.d_param;
  assign m0_if.d_size    = s_if.d_size;
  assign m0_if.d_source  = s_if.d_source[SRC_W-1:0];
  assign m0_if.d_sink    = s_if.d_sink;
  assign m0_if.d_denied  = s_if.d_denied;
  assign m0_if.d_corrupt = s_if.d_corrupt;
  assign m0_if.d_data    = s_if.d_data;

  assign m1_if.d_opcode  = s_if.d_opcode;
  assign m1_if.d_param   = s_if.d_param;
  assign m1_if.d_size    = s_if.d_size;
  assign m1_if.d_source  = s_if.d_source[SRC_W-1:0];
  assign m1_if.d_sink    = s_if.d_sink;
  assign m1_if.d_denied  = s_if.d_denied;
  assign m1_if.d_corrupt = s_if.d_corrupt;
  assign m1_if.d_data    = s_if.d_data;

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Bench for tl_ul_arb2: vector table from reset, directed multi-cycle cases,
// then randomized traffic against a transaction-level reference model.
module tb_tl_ul_arb2;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tl_ul_arb2_if #(.ADDR_W(26), .DATA_W(32), .SRC_W(2)) m0_if ();
  tl_ul_arb2_if #(.ADDR_W(26), .DATA_W(32), .SRC_W(2)) m1_if ();
  tl_ul_arb2_if #(.ADDR_W(26), .DATA_W(32), .SRC_W(3)) s_if ();

  tl_ul_arb2 #(.ADDR_W(26), .DATA_W(32), .SRC_W(2)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .m0_if  (m0_if),
    .m1_if  (m1_if),
    .s_if   (s_if)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic set_m(input int idx, input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [1:0] src, input logic [25:0] adr);
    if (idx == 0) begin
      m0_if.a_valid = v; m0_if.a_opcode = op; m0_if.a_size = sz;
      m0_if.a_source = src; m0_if.a_address = adr; m0_if.a_data = {6'd0, adr};
    end else begin
      m1_if.a_valid = v; m1_if.a_opcode = op; m1_if.a_size = sz;
      m1_if.a_source = src; m1_if.a_address = adr; m1_if.a_data = {6'd1, adr};
    end
  endtask

  task automatic idle_inputs();
    set_m(0, 0, 3'd4, 3'd2, 2'd0, 26'd0);
    set_m(1, 0, 3'd4, 3'd2, 2'd0, 26'd0);
    m0_if.a_param = 0; m0_if.a_mask = 4'hF; m0_if.a_corrupt = 0; m0_if.d_ready = 0;
    m1_if.a_param = 0; m1_if.a_mask = 4'hF; m1_if.a_corrupt = 0; m1_if.d_ready = 0;
    s_if.a_ready = 0; s_if.d_valid = 0; s_if.d_opcode = 3'd1; s_if.d_param = 0;
    s_if.d_size = 3'd2; s_if.d_source = 0; s_if.d_sink = 0; s_if.d_denied = 0;
    s_if.d_corrupt = 0; s_if.d_data = 32'hDEADBEEF;
  endtask

  // Leaves the bench 2 time units after a negedge, i.e. before the next posedge.
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    idle_inputs();
    #1 reset_n = 1'b1;
    #1;
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    string       nm;
    logic        v0, v1;
    logic [1:0]  src0, src1;
    logic [25:0] adr0, adr1;
    logic        srdy;
    logic        dv;
    logic [2:0]  dsrc;
    logic        dr0, dr1;
    logic        e_r0, e_r1, e_sv;
    logic [2:0]  e_ssrc;
    logic [25:0] e_sadr;
    logic        e_dv0, e_dv1, e_sdr;
    logic [1:0]  e_dsrc;
  } vec_t;

  vec_t vecs[6];

  // Reference model: burst beats still owed, pending stalled beat, last winner.
  int mb_left;
  bit mb_own;
  bit mp;
  bit mp_own;
  bit m_last;

  function automatic bit model_grant(input bit v0, input bit v1);
    if (mb_left > 0) return mb_own;
    if (mp) return mp_own;
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return !m_last;
  endfunction

  initial begin
    bit v0, v1, g, sv, srdy, fire;
    logic [2:0] op0, op1, sz0, sz1, gop, gsz;
    logic [1:0] s0, s1;
    logic [25:0] a0, a1;
    logic [2:0] ops[3];

    idle_inputs();
    #2;

    // name,v0,v1,src0,src1,adr0,adr1,srdy,dv,dsrc,dr0,dr1, r0,r1,sv,ssrc,sadr,dv0,dv1,sdr,dsrc
    vecs[0] = '{"idle",       0,0, 2'd0,2'd0, 26'h0,  26'h0,  0, 0,3'b000,0,0, 0,0,0,3'b000,26'h0,  0,0,0,2'b00};
    vecs[1] = '{"single_m0",  1,0, 2'd1,2'd0, 26'h100,26'h200,1, 1,3'b110,1,0, 1,0,1,3'b001,26'h100,0,1,0,2'b10};
    vecs[2] = '{"single_m1",  0,1, 2'd0,2'd2, 26'h100,26'h200,1, 1,3'b110,0,1, 0,1,1,3'b110,26'h200,0,1,1,2'b10};
    vecs[3] = '{"contend_m0", 1,1, 2'd3,2'd1, 26'h3c, 26'h40, 1, 1,3'b001,1,0, 1,0,1,3'b011,26'h3c, 1,0,1,2'b01};
    vecs[4] = '{"stall_m1",   0,1, 2'd0,2'd3, 26'h0,  26'h44, 0, 0,3'b111,1,1, 0,0,1,3'b111,26'h44, 0,0,1,2'b11};
    vecs[5] = '{"d_m0_busy",  1,0, 2'd2,2'd0, 26'h8,  26'h0,  0, 1,3'b010,0,1, 0,0,1,3'b010,26'h8,  1,0,0,2'b10};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      set_m(0, vecs[i].v0, 3'd4, 3'd2, vecs[i].src0, vecs[i].adr0);
      set_m(1, vecs[i].v1, 3'd4, 3'd2, vecs[i].src1, vecs[i].adr1);
      s_if.a_ready = vecs[i].srdy;
      s_if.d_valid = vecs[i].dv;
      s_if.d_source = vecs[i].dsrc;
      m0_if.d_ready = vecs[i].dr0;
      m1_if.d_ready = vecs[i].dr1;
      #1;
      chk({vecs[i].nm, ".m0_a_ready"}, 32'(m0_if.a_ready), 32'(vecs[i].e_r0));
      chk({vecs[i].nm, ".m1_a_ready"}, 32'(m1_if.a_ready), 32'(vecs[i].e_r1));
      chk({vecs[i].nm, ".s_a_valid"},  32'(s_if.a_valid),  32'(vecs[i].e_sv));
      if (vecs[i].e_sv) begin
        chk({vecs[i].nm, ".s_a_source"},  32'(s_if.a_source),  32'(vecs[i].e_ssrc));
        chk({vecs[i].nm, ".s_a_address"}, 32'(s_if.a_address), 32'(vecs[i].e_sadr));
      end
      chk({vecs[i].nm, ".m0_d_valid"}, 32'(m0_if.d_valid), 32'(vecs[i].e_dv0));
      chk({vecs[i].nm, ".m1_d_valid"}, 32'(m1_if.d_valid), 32'(vecs[i].e_dv1));
      chk({vecs[i].nm, ".s_d_ready"},  32'(s_if.d_ready),  32'(vecs[i].e_sdr));
      chk({vecs[i].nm, ".m0_d_source"}, 32'(m0_if.d_source), 32'(vecs[i].e_dsrc));
      chk({vecs[i].nm, ".m1_d_source"}, 32'(m1_if.d_source), 32'(vecs[i].e_dsrc));
      chk({vecs[i].nm, ".m1_d_data"},  m1_if.d_data, 32'hDEADBEEF);
    end

    // Contention: back-to-back Gets alternate m0, m1, m0, m1.
    do_reset();
    set_m(0, 1, 3'd4, 3'd2, 2'd0, 26'h10);
    set_m(1, 1, 3'd4, 3'd2, 2'd1, 26'h20);
    s_if.a_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin next_cyc(); #1; end
      chk($sformatf("rr_owner_c%0d", i), 32'(s_if.a_source[2]), 32'(i % 2));
      chk($sformatf("rr_m%0d_ready_c%0d", i % 2, i),
          32'((i % 2 == 0) ? m0_if.a_ready : m1_if.a_ready), 32'd1);
    end

    // Burst lock: m0 PutFull size 4 holds the port for 4 beats.
    do_reset();
    set_m(0, 1, 3'd0, 3'd4, 2'd2, 26'h1000);
    s_if.a_ready = 1;
    #1;
    chk("burst_beat1_owner", 32'(s_if.a_source[2]), 32'd0);
    for (int b = 2; b <= 4; b++) begin
      next_cyc();
      set_m(0, 1, 3'd0, 3'd4, 2'd2, 26'h1000);
      set_m(1, 1, 3'd4, 3'd2, 2'd3, 26'h2000);
      #1;
      chk($sformatf("burst_beat%0d_m1_ready", b), 32'(m1_if.a_ready), 32'd0);
      chk($sformatf("burst_beat%0d_m0_ready", b), 32'(m0_if.a_ready), 32'd1);
    end
    next_cyc();
    set_m(0, 0, 3'd4, 3'd2, 2'd0, 26'h0);
    #1;
    chk("burst_after_m1_ready", 32'(m1_if.a_ready), 32'd1);
    chk("burst_after_owner", 32'(s_if.a_source[2]), 32'd1);

    // Stall hold: m1 presented with s_a_ready low keeps the grant despite m0.
    do_reset();
    set_m(1, 1, 3'd4, 3'd2, 2'd2, 26'h55);
    #1;
    chk("hold_c1_owner", 32'(s_if.a_source[2]), 32'd1);
    for (int c = 2; c <= 3; c++) begin
      next_cyc();
      set_m(0, 1, 3'd4, 3'd2, 2'd0, 26'h77);
      #1;
      chk($sformatf("hold_c%0d_owner", c), 32'(s_if.a_source[2]), 32'd1);
      chk($sformatf("hold_c%0d_addr", c), 32'(s_if.a_address), 32'h55);
      chk($sformatf("hold_c%0d_m0_ready", c), 32'(m0_if.a_ready), 32'd0);
    end
    next_cyc();
    s_if.a_ready = 1;
    #1;
    chk("hold_c4_m1_ready", 32'(m1_if.a_ready), 32'd1);
    chk("hold_c4_addr", 32'(s_if.a_address), 32'h55);
    next_cyc();
    set_m(1, 0, 3'd4, 3'd2, 2'd0, 26'h0);
    #1;
    chk("hold_c5_m0_ready", 32'(m0_if.a_ready), 32'd1);

    // Reset mid-burst: lock and round-robin history drop asynchronously.
    do_reset();
    set_m(0, 1, 3'd0, 3'd4, 2'd1, 26'h300);
    s_if.a_ready = 1;
    next_cyc();
    next_cyc();
    set_m(0, 0, 3'd0, 3'd4, 2'd1, 26'h300);
    set_m(1, 1, 3'd4, 3'd2, 2'd0, 26'h400);
    #1;
    chk("rst_pre_m1_ready", 32'(m1_if.a_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_async_m1_ready", 32'(m1_if.a_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    set_m(0, 1, 3'd4, 3'd2, 2'd1, 26'h500);
    #1;
    chk("rst_after_owner", 32'(s_if.a_source[2]), 32'd0);
    chk("rst_after_m0_ready", 32'(m0_if.a_ready), 32'd1);

    // Randomized traffic against the reference model.
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4;
    do_reset();
    mb_left = 0; mb_own = 0; mp = 0; mp_own = 0; m_last = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      op0 = ops[$urandom_range(0, 2)]; op1 = ops[$urandom_range(0, 2)];
      sz0 = 3'($urandom_range(0, 5)); sz1 = 3'($urandom_range(0, 5));
      s0 = 2'($urandom); s1 = 2'($urandom);
      a0 = 26'($urandom); a1 = 26'($urandom);
      srdy = ($urandom_range(0, 3) != 0);
      set_m(0, v0, op0, sz0, s0, a0);
      set_m(1, v1, op1, sz1, s1, a1);
      s_if.a_ready = srdy;
      s_if.d_valid = 1'($urandom);
      s_if.d_source = 3'($urandom);
      s_if.d_data = $urandom;
      m0_if.d_ready = 1'($urandom);
      m1_if.d_ready = 1'($urandom);
      #1;
      g = model_grant(v0, v1);
      sv = g ? v1 : v0;
      chk("rnd_m0_a_ready", 32'(m0_if.a_ready), 32'(srdy & !g));
      chk("rnd_m1_a_ready", 32'(m1_if.a_ready), 32'(srdy & g));
      chk("rnd_s_a_valid", 32'(s_if.a_valid), 32'(sv));
      chk("rnd_s_a_source", 32'(s_if.a_source), 32'({g, (g ? s1 : s0)}));
      chk("rnd_s_a_address", 32'(s_if.a_address), 32'(g ? a1 : a0));
      chk("rnd_m0_d_valid", 32'(m0_if.d_valid), 32'(s_if.d_valid & !s_if.d_source[2]));
      chk("rnd_m1_d_valid", 32'(m1_if.d_valid), 32'(s_if.d_valid & s_if.d_source[2]));
      chk("rnd_s_d_ready", 32'(s_if.d_ready),
          32'(s_if.d_source[2] ? m1_if.d_ready : m0_if.d_ready));
      chk("rnd_m0_d_data", m0_if.d_data, s_if.d_data);
      // Advance the model by this cycle's handshake.
      fire = sv & srdy;
      gop = g ? op1 : op0;
      gsz = g ? sz1 : sz0;
      if (mb_left > 0) begin
        if (fire) mb_left--;
      end else if (fire) begin
        mp = 0;
        m_last = g;
        if ((gop == 3'd0 || gop == 3'd1) && gsz > 3'd2) begin
          mb_left = (1 << (int'(gsz) - 2)) - 1;
          mb_own = g;
        end
      end else if (sv) begin
        mp = 1;
        mp_own = g;
      end
      next_cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_ul_arb2.md
# tl_ul_arb2

Two-master TileLink-UL/UH arbiter that shares one 32-bit slave port between two requesters (for example, core data port and debug/DMA port). It sits directly upstream of the port pass-through stage. It arbitrates the A channel round-robin and locks the grant for multi-beat Put bursts. It widens the source ID by one bit to tag the owner, and routes D-channel responses back by that tag.

## Interface
- ADDR_W, 26, A-channel address width
- DATA_W, 32, data width; mask width = DATA_W/8; beat size log2 LGB = 2
- SRC_W, 2, master source width; slave source width = SRC_W+1
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- mN_a_valid / mN_a_ready  in/out  1  master N (N=0,1) A handshake
- mN_a_opcode, mN_a_param, mN_a_size  in  3 each  master N A fields
- mN_a_source  in  SRC_W  master N source
- mN_a_address  in  ADDR_W
- mN_a_mask  in  4
- mN_a_data  in  32
- mN_a_corrupt  in  1
- s_a_valid / s_a_ready  out/in  1  slave A handshake
- s_a_opcode, s_a_param, s_a_size  out  3 each
- s_a_source  out  SRC_W+1  {owner, master source}
- s_a_address, s_a_mask, s_a_data, s_a_corrupt  out  muxed from granted master
- s_d_valid / s_d_ready  in/out  1  slave D handshake
- s_d_opcode  in  3
- s_d_param  in  2
- s_d_size  in  3
- s_d_source  in  SRC_W+1
- s_d_sink, s_d_denied, s_d_corrupt  in  1 each
- s_d_data  in  32
- mN_d_valid / mN_d_ready  out/in  1  master N D handshake
- mN_d_*  out  same fields as s_d_*; mN_d_source is SRC_W wide (tag stripped)

## Operation
- State: `lock` (1b), `lock_owner` (1b), `hold` (1b), `hold_owner` (1b), `beats_left` (up to 8b), `rr_last` (1b).
- Grant selection:
  - If lock=1, grant = lock_owner.
  - Otherwise, if hold=1, grant = hold_owner.
  - Otherwise, if only one master is valid, grant goes to it.
  - If both are valid, grant = ~rr_last.
- Only the granted master sees mN_a_ready = s_a_ready. The other master's ready = 0.
- s_a_valid = granted master's valid. s_a_source = {grant, mG_a_source}.
- Fire = s_a_valid & s_a_ready.
- First-beat fire:
  - rr_last <= grant.
  - If opcode is PutFull (0) or PutPartial (1) and size > LGB, then lock <= 1, lock_owner <= grant, and beats_left <= (1 << (size-LGB)) - 1.
- Locked fire: beats_left decrements. On the fire with beats_left == 1, lock <= 0.
- Stall hold:
  - If s_a_valid & ~s_a_ready while unlocked, then hold <= 1 and hold_owner <= grant. The grant must not change while a presented beat is pending.
  - hold clears on the fire.
- Get, or any size ≤ LGB: single A beat, no lock.
- D routing is stateless. Tag = s_d_source[SRC_W] selects the master.
  - m(tag)_d_valid = s_d_valid; the other master's d_valid = 0.
  - s_d_ready = m(tag)_d_ready.
  - All other D fields are broadcast to both masters; mN_d_source = s_d_source[SRC_W-1:0].
- Locked master deasserting valid mid-burst: the grant stays locked and s_a_valid = 0 until the remaining beats arrive.

## Timing
- A and D paths are combinational: zero added latency, no bubbles between back-to-back grants.
- Reset values:
  - lock = 0, hold = 0, beats_left = 0.
  - rr_last = 1, so m0 wins the first contention.
- Output values with all inputs idle: all mN_a_ready = 0, s_a_valid = 0, mN_d_valid = 0.
- Reset asserted mid-burst clears lock/hold immediately (asynchronously). No partial-burst recovery is performed.
- Simultaneous first-beat fire and new request from the other master: the new request is granted next cycle if the fire was single-beat, otherwise after the burst ends.
- beats_left width: 8 bits, covering size up to 10 (256 beats). Sizes > 10 are illegal and are not checked.

## Test plan
- Single request:
  - Stimulus: m0 Get, size 2, addr 0x100, source 1; s_a_ready = 1.
  - Required: same-cycle s_a_valid = 1 with s_a_source = 3'b001. m1_a_ready stays 0.
- Contention:
  - Stimulus: m0 and m1 both present Gets continuously; s_a_ready = 1.
  - Required: grants alternate m0, m1, m0, m1 across 4 cycles.
- Burst lock:
  - Stimulus: m0 PutFull size 4 (4 beats); m1 requests from cycle 1.
  - Required: m1_a_ready = 0 for all 4 beats. m1 is granted in the cycle after beat 4 fires.
- Stall hold:
  - Stimulus: m1 granted, s_a_ready held 0 for 3 cycles while m0 becomes valid.
  - Required: grant stays m1 with fields stable; m1 fires in cycle 4.
- D routing:
  - Stimulus: s_d_source = 3'b110, data 0xDEADBEEF.
  - Required: m1_d_valid = 1, m1_d_source = 2'b10, m0_d_valid = 0. s_d_ready tracks m1_d_ready.
- Reset mid-burst:
  - Stimulus: assert reset_n = 0 after beat 2 of a 4-beat burst, then release.
  - Required: lock = 0 immediately. The first contention after release grants m0.
